// File: rtl/fir_da_param_if.sv
// fir_da_param_if: sample-in / result-out bundle for the DA FIR.
// din/in_valid/in_ready (input handshake), dout/out_valid (result strobe).
interface fir_da_param_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic signed [DATA_W-1:0] din;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OUT_W-1:0]  dout;
  logic                     out_valid;

  modport master (
    output din, in_valid,
    input  in_ready, dout, out_valid
  );

  modport slave (
    input  din, in_valid,
    output in_ready, dout, out_valid
  );
endinterface

// File: rtl/fir_da_param.sv
// fir_da_param: bit-serial distributed-arithmetic FIR, rounded+saturated out.
// Ports: clk, rst (sync, active-high), bus (slave: din/in_valid/in_ready/dout/out_valid).
module fir_da_param #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 4,
  parameter int COEF_W = 8,
  parameter logic [TAPS*COEF_W-1:0] COEFS = {8'sd4, 8'sd3, 8'sd2, 8'sd1},
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  fir_da_param_if.slave  bus
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS) + 1;
  localparam int LUT_W = COEF_W + $clog2(TAPS);
  localparam int KW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int RW    = ACC_W + 2;
  localparam int NLUT  = 2 ** TAPS;

  localparam logic [KW-1:0] K_LAST = KW'(DATA_W - 1);

  // Rounding is done at one extra fractional bit:
  // (2*acc + 2^SHIFT) >>> (SHIFT+1) == round-half-up of acc / 2^SHIFT,
  // and degenerates to acc itself when SHIFT is 0.
  localparam logic signed [RW-1:0] RND  = RW'(1) <<< SHIFT;
  localparam logic signed [RW-1:0] OMAX = RW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] OMIN = RW'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  function automatic logic signed [LUT_W-1:0] coef(input int i);
    logic signed [COEF_W-1:0] c;
    c = COEFS[i*COEF_W +: COEF_W];
    return LUT_W'(c);
  endfunction

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] tap_q [TAPS];
  logic signed [DATA_W-1:0] tap_d [TAPS];

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [KW-1:0]           k_q, k_d;
  logic [OUT_W-1:0]        dout_q, dout_d;
  logic                    ov_q, ov_d;

  logic signed [LUT_W-1:0] lut [NLUT];
  logic [TAPS-1:0]         addr;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_nx;
  logic signed [RW-1:0]    rnd_sum;
  logic signed [RW-1:0]    r;
  logic [OUT_W-1:0]        sat;

  // LUT[a] = sum of the coefficients whose tap bit is set in a
  always_comb begin
    for (int a = 0; a < NLUT; a++) begin
      lut[a] = '0;
      for (int i = 0; i < TAPS; i++) begin
        if (a[i]) lut[a] = lut[a] + coef(i);
      end
    end
  end

  // one bit-plane of the delay line per SHIFT cycle
  always_comb begin
    addr = '0;
    for (int i = 0; i < TAPS; i++) begin
      addr[i] = tap_q[i][k_q];
    end
  end

  // the sign-bit plane carries negative weight
  always_comb begin
    term   = ACC_W'(lut[addr]) <<< k_q;
    acc_nx = (k_q == K_LAST) ? acc_q - term : acc_q + term;
  end

  always_comb begin
    rnd_sum = (RW'(acc_nx) <<< 1) + RND;
    r       = rnd_sum >>> (SHIFT + 1);
    if (r > OMAX) begin
      sat = OUT_W'(OMAX);
    end else if (r < OMIN) begin
      sat = OUT_W'(OMIN);
    end else begin
      sat = OUT_W'(r);
    end
  end

  // The result is registered on the final SHIFT edge so it is
  // visible, together with out_valid, throughout the DONE cycle.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    k_d     = k_q;
    dout_d  = dout_q;
    ov_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          tap_d[0] = bus.din;
          for (int i = 1; i < TAPS; i++) begin
            tap_d[i] = tap_q[i-1];
          end
          acc_d   = '0;
          k_d     = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = acc_nx;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          dout_d  = sat;
          ov_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < TAPS; i++) begin
        tap_q[i] <= '0;
      end
      acc_q  <= '0;
      k_q    <= '0;
      dout_q <= '0;
      ov_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < TAPS; i++) begin
        tap_q[i] <= tap_d[i];
      end
      acc_q  <= acc_d;
      k_q    <= k_d;
      dout_q <= dout_d;
      ov_q   <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.dout      = dout_q;
  assign bus.out_valid = ov_q;

endmodule
